// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: sequences PLL reset, lock qualification and downstream release; define PLL_LOSS_COUNT_EN to add the lost_count port
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retries
`ifdef PLL_LOSS_COUNT_EN
    ,
    output logic [7:0] lost_count
`endif
);
    localparam int MAX_AB = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_P  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_P + 1);

    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lk_m, lk_s;
    logic          timeout, loss;

    assign pll_rst   = (state == PLL_RST);
    assign sys_reset = (state != RUN);
    assign ready     = (state == RUN);

    // next-state and shared counter; the lock sample that leaves WAIT_LOCK is stable sample 1
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        timeout = 1'b0;
        loss    = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_n = (STABLE_CYCLES == 1) ? RUN : STABLE;
                    cnt_n   = CW'(1);
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = PLL_RST;
                    cnt_n   = '0;
                    timeout = 1'b1;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!lk_s) begin
                    state_n = PLL_RST;
                    loss    = 1'b1;
                end
            end
            default: begin
                state_n = PLL_RST;
                cnt_n   = '0;
            end
        endcase
    end

    // lock synchronizer, state/counter register, loss pulse and saturating retry count
    always_ff @(posedge refclk) begin
        if (rst) begin
            {lk_s, lk_m} <= 2'b00;
            state        <= PLL_RST;
            cnt          <= '0;
            lock_lost    <= 1'b0;
            retries      <= '0;
        end else begin
            {lk_s, lk_m} <= {lk_m, pll_locked};
            state        <= state_n;
            cnt          <= cnt_n;
            lock_lost    <= loss;
            if (timeout && retries != 4'hF) retries <= retries + 1'b1;
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    // saturating count of lock-loss events, advancing with each lock_lost pulse
    always_ff @(posedge refclk) begin
        if (rst) lost_count <= '0;
        else if (loss && lost_count != 8'hFF) lost_count <= lost_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenarios plus randomized lock traffic against a behavioural model
module tb_pll_reset_sequencer;
    localparam int P = 4, S = 8, T = 20;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_reset, ready, lock_lost;
    logic [3:0] retries;
`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] lost_count;
`endif

    int checks = 0;
    int passed = 0;

    int     m_rst_left, m_wait, m_streak, m_retries, m_lost;
    bit     m_run, m_pulse;
    bit [1:0] m_sync;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(P),
        .STABLE_CYCLES(S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .sys_reset(sys_reset),
        .ready(ready),
        .lock_lost(lock_lost),
        .retries(retries)
`ifdef PLL_LOSS_COUNT_EN
        ,
        .lost_count(lost_count)
`endif
    );

    task automatic tick();
        bit lk;
        @(posedge refclk);
        if (rst) begin
            m_sync = 2'b00; m_rst_left = P; m_wait = 0; m_streak = 0;
            m_run = 0; m_retries = 0; m_lost = 0; m_pulse = 0;
        end else begin
            lk = m_sync[1];
            m_sync = {m_sync[0], pll_locked};
            m_pulse = 0;
            if (m_rst_left > 0) begin
                m_rst_left--;
                m_wait = 0;
                m_streak = 0;
            end else if (m_run) begin
                if (!lk) begin
                    m_run = 0; m_rst_left = P; m_pulse = 1;
                    m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                end
            end else if (lk) begin
                m_streak++;
                if (m_streak >= S) m_run = 1;
            end else if (m_streak > 0) begin
                m_streak = 0;
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == T) begin
                    m_rst_left = P; m_wait = 0;
                    m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; pll_locked = 0;
        repeat (3) tick();
        checks++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); else passed++;
        checks++; if (sys_reset !== 1'b1) $display("FAIL reset_sys_reset: got %b expected 1", sys_reset); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else passed++;
        checks++; if (lock_lost !== 1'b0) $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); else passed++;
        checks++; if (retries !== 4'd0) $display("FAIL reset_retries: got %0d expected 0", retries); else passed++;
`ifdef PLL_LOSS_COUNT_EN
        checks++; if (lost_count !== 8'd0) $display("FAIL reset_lost_count: got %0d expected 0", lost_count); else passed++;
`endif
    endtask

    task automatic test_clean_lock();
        logic [9:0] seen;
        int n;
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            seen[i] = pll_rst;
            tick();
        end
        checks++; if (seen !== 10'b0000001111) $display("FAIL clean_pll_rst_window: got %b expected 0000001111", seen); else passed++;
        pll_locked = 1;
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        checks++; if (n !== 10) $display("FAIL clean_ready_latency: got %0d expected 10", n); else passed++;
        checks++; if (sys_reset !== 1'b0) $display("FAIL clean_sys_reset: got %b expected 0", sys_reset); else passed++;
        checks++; if (retries !== 4'd0) $display("FAIL clean_retries: got %0d expected 0", retries); else passed++;
        checks++; if (ready !== m_run) $display("FAIL clean_model_ready: got %b expected %b", ready, m_run); else passed++;
    endtask

    task automatic test_loss_in_run();
        logic [5:0] pr, ll, sr;
        int n;
        pll_locked = 0;
        n = 0;
        while (!pll_rst && n < 20) begin tick(); n++; end
        checks++; if (n !== 3) $display("FAIL loss_latency: got %0d expected 3", n); else passed++;
        for (int i = 0; i < 6; i++) begin
            pr[i] = pll_rst; ll[i] = lock_lost; sr[i] = sys_reset;
            tick();
        end
        checks++; if (pr !== 6'b001111) $display("FAIL loss_pll_rst: got %b expected 001111", pr); else passed++;
        checks++; if (ll !== 6'b000001) $display("FAIL loss_lock_lost: got %b expected 000001", ll); else passed++;
        checks++; if (sr !== 6'b111111) $display("FAIL loss_sys_reset: got %b expected 111111", sr); else passed++;
        checks++; if (retries !== 4'd0) $display("FAIL loss_retries: got %0d expected 0", retries); else passed++;
`ifdef PLL_LOSS_COUNT_EN
        checks++; if (lost_count !== 8'd1) $display("FAIL loss_lost_count: got %0d expected 1", lost_count); else passed++;
`endif
    endtask

    task automatic test_reset_in_run();
        logic [5:0] pr, ll;
        int n;
        pll_locked = 1;
        n = 0;
        while (!ready && n < 60) begin tick(); n++; end
        checks++; if (ready !== 1'b1) $display("FAIL rrun_reach_run: got %b expected 1", ready); else passed++;
        rst = 1; tick(); rst = 0;
        checks++; if ({pll_rst, sys_reset, ready, lock_lost, retries} !== 8'b1100_0000)
            $display("FAIL rrun_outputs: got %b expected 11000000", {pll_rst, sys_reset, ready, lock_lost, retries}); else passed++;
`ifdef PLL_LOSS_COUNT_EN
        checks++; if (lost_count !== 8'd0) $display("FAIL rrun_lost_count: got %0d expected 0", lost_count); else passed++;
`endif
        for (int i = 0; i < 6; i++) begin
            pr[i] = pll_rst; ll[i] = lock_lost;
            tick();
        end
        checks++; if (pr !== 6'b001111) $display("FAIL rrun_restart: got %b expected 001111", pr); else passed++;
        checks++; if (ll !== 6'b000000) $display("FAIL rrun_no_pulse: got %b expected 000000", ll); else passed++;
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        checks++; if (ready !== 1'b1) $display("FAIL rrun_relock: got %b expected 1", ready); else passed++;
    endtask

    task automatic test_no_lock();
        int exp_r;
        rst = 1; pll_locked = 0; tick(); rst = 0;
        for (int c = 0; c < 16 * (P + T) + 10; c++) begin
            exp_r = (c / (P + T) > 15) ? 15 : c / (P + T);
            checks++;
            if ({pll_rst, ready, retries} !== {((c % (P + T)) < P), 1'b0, 4'(exp_r)})
                $display("FAIL nolock_cycle%0d: got %b expected %b", c, {pll_rst, ready, retries}, {((c % (P + T)) < P), 1'b0, 4'(exp_r)});
            else passed++;
            tick();
        end
    endtask

    task automatic test_glitch();
        bit early;
        int n;
        rst = 1; pll_locked = 0; tick(); rst = 0;
        repeat (P) tick();
        early = 0;
        pll_locked = 1;
        repeat (5) begin tick(); early |= ready; end
        pll_locked = 0;
        tick(); early |= ready;
        pll_locked = 1;
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        checks++; if (early !== 1'b0) $display("FAIL glitch_early_ready: got %b expected 0", early); else passed++;
        checks++; if (n !== 10) $display("FAIL glitch_ready_latency: got %0d expected 10", n); else passed++;
        checks++; if (retries !== 4'd0) $display("FAIL glitch_retries: got %0d expected 0", retries); else passed++;
    endtask

    task automatic test_random();
        int len;
        len = 0;
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 1500; c++) begin
            if (len == 0) begin
                pll_locked = ($urandom_range(0, 2) != 0);
                len = pll_locked ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 40));
            end
            len--;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if ({pll_rst, sys_reset, ready, lock_lost, retries} !== {(m_rst_left > 0), !m_run, m_run, m_pulse, 4'(m_retries)})
                $display("FAIL random_cycle%0d: got %b expected %b", c, {pll_rst, sys_reset, ready, lock_lost, retries},
                         {(m_rst_left > 0), !m_run, m_run, m_pulse, 4'(m_retries)});
            else passed++;
`ifdef PLL_LOSS_COUNT_EN
            checks++;
            if (lost_count !== 8'(m_lost)) $display("FAIL random_lost_count%0d: got %0d expected %0d", c, lost_count, m_lost);
            else passed++;
`endif
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_loss_in_run();
        test_reset_in_run();
        test_no_lock();
        test_glitch();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
